serial_word_assembler: RTL and testbench

- Downstream consumer of a single-bit registered stream, such as the Q output of the flip-flop stage.
- Samples one serial bit per clock when qualified, and assembles WIDTH bits into a parallel word.
- Presents each completed word on a valid/ready output handshake.
- Double-buffered: a new word keeps shifting in while the previous word waits for acceptance.

---
 rtl/serial_word_assembler.sv | 123 ++++++++++++
 tb/tb_serial_word_assembler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_assembler.sv
// rtl/serial_word_assembler.sv - serial bit stream to parallel word assembler with double-buffered output
// Optional macro: SERIAL_WORD_ASSEMBLER_PARITY_EN (trailing even-parity bit per frame, adds parity_err)
module serial_word_assembler #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       d_in,
   input  logic                       d_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       overflow,
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
   output logic                       parity_err,
`endif
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

   buf_state_t       buf_state;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_next;
   logic [WIDTH-1:0] word;
   logic             complete;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
   logic             word_perr;
`endif

   // Next shift-register value if the current bit is a data bit
   always_comb begin
      shift_next = shift_q;
      if (MSB_FIRST) begin
         shift_next = {shift_q[WIDTH-2:0], d_in};
      end else begin
         shift_next = {d_in, shift_q[WIDTH-1:1]};
      end
   end

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
   // Frame ends on the parity bit, which follows WIDTH data bits and is not shifted in
   always_comb begin
      complete  = d_valid && (bit_cnt == CW'(WIDTH));
      word      = shift_q;
      word_perr = (^shift_q) ^ d_in;
   end
`else
   // Frame ends on the WIDTH-th data bit; the word includes that bit
   always_comb begin
      complete = d_valid && (bit_cnt == CW'(WIDTH - 1));
      word     = shift_next;
   end
`endif

   // Serial capture: append qualified bits, restart cleanly after each frame
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         bit_cnt <= '0;
      end else if (d_valid) begin
         if (complete) begin
            shift_q <= '0;
            bit_cnt <= '0;
         end else begin
            shift_q <= shift_next;
            bit_cnt <= bit_cnt + CW'(1);
         end
      end
   end

   // Output buffer: holds one finished word until accepted; drops newer words when blocked
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_state  <= BUF_EMPTY;
         out_valid  <= 1'b0;
         out_data   <= '0;
         overflow   <= 1'b0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         case (buf_state)
            BUF_EMPTY: begin
               if (complete) begin
                  buf_state  <= BUF_FULL;
                  out_valid  <= 1'b1;
                  out_data   <= word;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
                  parity_err <= word_perr;
`endif
               end
            end
            BUF_FULL: begin
               if (out_ready) begin
                  if (complete) begin
                     out_data   <= word;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
                     parity_err <= word_perr;
`endif
                  end else begin
                     buf_state <= BUF_EMPTY;
                     out_valid <= 1'b0;
                  end
               end else if (complete) begin
                  overflow <= 1'b1;
               end
            end
            default: begin
               buf_state <= BUF_EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_word_assembler.sv
// tb/tb_serial_word_assembler.sv - randomized and directed bench for serial_word_assembler against a queue-based model
module tb_serial_word_assembler;

   localparam int W  = 8;
   localparam int CW = $clog2(W+1);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif

   logic          clk = 1'b0;
   logic          rst, d_in, d_valid, out_ready;
   logic [W-1:0]  data_m, data_l;
   logic          valid_m, valid_l, ovf_m, ovf_l;
   logic [CW-1:0] cnt_m, cnt_l;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
   logic          perr_m, perr_l;
`endif

   int total = 0;
   int bad   = 0;

   bit            mq[$];
   logic          m_valid, m_ovf, m_perr;
   logic [W-1:0]  m_data_m, m_data_l;

   always #5 clk = ~clk;

   serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid),
      .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready), .overflow(ovf_m),
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      .parity_err(perr_m),
`endif
      .bit_cnt(cnt_m)
   );

   serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid),
      .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready), .overflow(ovf_l),
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      .parity_err(perr_l),
`endif
      .bit_cnt(cnt_l)
   );

   // Drive one clock of inputs, advance the reference model, settle past the edge
   task automatic step(input logic r, input logic b, input logic v, input logic rdy);
      logic         complete;
      logic [W-1:0] wm, wl;
      logic         px;
      rst = r; d_in = b; d_valid = v; out_ready = rdy;
      @(posedge clk);
      complete = 1'b0; wm = '0; wl = '0; px = 1'b0;
      if (r) begin
         mq.delete();
         m_valid = 1'b0; m_ovf = 1'b0; m_perr = 1'b0; m_data_m = '0; m_data_l = '0;
      end else begin
         if (v) begin
            mq.push_back(b);
            if (mq.size() == FRAME) begin
               complete = 1'b1;
               for (int i = 0; i < W; i++) begin
                  wm[W-1-i] = mq[i];
                  wl[i]     = mq[i];
               end
               foreach (mq[i]) px = px ^ mq[i];
               mq.delete();
            end
         end
         if (complete && (!m_valid || rdy)) begin
            m_valid = 1'b1; m_data_m = wm; m_data_l = wl; m_perr = px;
         end else if (complete) begin
            m_ovf = 1'b1;
         end else if (m_valid && rdy) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   // Send one frame in transmit order val[W-1] first; out_ready only on the final edge
   task automatic send_word(input logic [W-1:0] val, input logic rdy_last);
      for (int i = 0; i < FRAME; i++) begin
         logic b;
         b = (i < W) ? val[W-1-i] : ^val;
         step(1'b0, b, 1'b1, (i == FRAME-1) ? rdy_last : 1'b0);
      end
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      total++;
      if ({valid_m, ovf_m, cnt_m, data_m, valid_l, ovf_l, cnt_l, data_l} !== '0) begin
         bad++;
         $display("FAIL reset_state: got v=%b o=%b c=%0d d=%h / v=%b o=%b c=%0d d=%h, want all zero",
                  valid_m, ovf_m, cnt_m, data_m, valid_l, ovf_l, cnt_l, data_l);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] val;
      val = 8'hA5;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < FRAME; i++) begin
         step(1'b0, (i < W) ? val[W-1-i] : ^val, 1'b1, 1'b0);
         if (i == FRAME-2) begin
            total++;
            if (valid_m !== 1'b0 || cnt_m !== CW'(FRAME-1)) begin
               bad++;
               $display("FAIL basic_pre_complete: got valid=%b cnt=%0d, want valid=0 cnt=%0d", valid_m, cnt_m, FRAME-1);
            end
         end
      end
      total++;
      if ({valid_m, ovf_m, cnt_m, data_m} !== {1'b1, 1'b0, CW'(0), 8'hA5}) begin
         bad++;
         $display("FAIL basic_word: got valid=%b ovf=%b cnt=%0d data=%h, want 1 0 0 a5", valid_m, ovf_m, cnt_m, data_m);
      end
      total++;
      if ({valid_l, data_l} !== {1'b1, m_data_l}) begin
         bad++;
         $display("FAIL basic_word_lsb: got valid=%b data=%h, want 1 %h", valid_l, data_l, m_data_l);
      end
   endtask

   task automatic test_gap();
      logic [W-1:0] val;
      val = 8'hA5;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < FRAME; i++) begin
         step(1'b0, (i < W) ? val[W-1-i] : ^val, 1'b1, 1'b0);
         if (i == 3) begin
            for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0, 1'b1);
            total++;
            if (cnt_l !== CW'(4) || cnt_m !== CW'(4) || valid_l !== 1'b0) begin
               bad++;
               $display("FAIL gap_hold: got cnt=%0d/%0d valid=%b, want cnt=4/4 valid=0", cnt_m, cnt_l, valid_l);
            end
         end
      end
      total++;
      if ({valid_l, data_l} !== {1'b1, 8'hA5}) begin
         bad++;
         $display("FAIL gap_word_lsb: got valid=%b data=%h, want 1 a5", valid_l, data_l);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if ({valid_l, data_l} !== {1'b0, 8'hA5}) begin
         bad++;
         $display("FAIL gap_accept: got valid=%b data=%h, want 0 a5", valid_l, data_l);
      end
      send_word(8'hC0, 1'b0);
      total++;
      if ({valid_l, data_l, valid_m, data_m} !== {1'b1, 8'h03, 1'b1, 8'hC0}) begin
         bad++;
         $display("FAIL order_word: got lsb=%b/%h msb=%b/%h, want 1/03 1/c0", valid_l, data_l, valid_m, data_m);
      end
   endtask

   task automatic test_overflow();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      send_word(8'h11, 1'b0);
      total++;
      if ({valid_m, ovf_m, data_m} !== {1'b1, 1'b0, 8'h11}) begin
         bad++;
         $display("FAIL ovf_first: got valid=%b ovf=%b data=%h, want 1 0 11", valid_m, ovf_m, data_m);
      end
      send_word(8'h22, 1'b0);
      total++;
      if ({valid_m, ovf_m, data_m, ovf_l} !== {1'b1, 1'b1, 8'h11, 1'b1}) begin
         bad++;
         $display("FAIL ovf_drop: got valid=%b ovf=%b data=%h ovf_l=%b, want 1 1 11 1", valid_m, ovf_m, data_m, ovf_l);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if ({valid_m, ovf_m} !== {1'b0, 1'b1}) begin
         bad++;
         $display("FAIL ovf_sticky: got valid=%b ovf=%b, want 0 1", valid_m, ovf_m);
      end
   endtask

   task automatic test_back_to_back();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b1);
      total++;
      if ({valid_m, ovf_m, data_m} !== {1'b1, 1'b0, 8'h22}) begin
         bad++;
         $display("FAIL simul_accept: got valid=%b ovf=%b data=%h, want 1 0 22", valid_m, ovf_m, data_m);
      end
      total++;
      if ({valid_l, ovf_l, data_l} !== {1'b1, 1'b0, m_data_l}) begin
         bad++;
         $display("FAIL simul_accept_lsb: got valid=%b ovf=%b data=%h, want 1 0 %h", valid_l, ovf_l, data_l, m_data_l);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      total++;
      if (cnt_m !== CW'(5)) begin
         bad++;
         $display("FAIL midword_count: got cnt=%0d, want 5", cnt_m);
      end
      step(1'b1, 1'b1, 1'b1, 1'b0);
      total++;
      if ({cnt_m, valid_m, cnt_l} !== {CW'(0), 1'b0, CW'(0)}) begin
         bad++;
         $display("FAIL midword_reset: got cnt=%0d valid=%b cnt_l=%0d, want 0 0 0", cnt_m, valid_m, cnt_l);
      end
      send_word(8'h3C, 1'b0);
      total++;
      if ({valid_m, data_m, data_l} !== {1'b1, 8'h3C, m_data_l}) begin
         bad++;
         $display("FAIL midword_clean: got valid=%b data=%h data_l=%h, want 1 3c %h", valid_m, data_m, data_l, m_data_l);
      end
   endtask

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
   task automatic test_parity();
      logic [W-1:0] val;
      val = 8'hA5;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < W; i++) step(1'b0, val[W-1-i], 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if ({valid_m, perr_m, data_m} !== {1'b1, 1'b0, 8'hA5}) begin
         bad++;
         $display("FAIL parity_good: got valid=%b perr=%b data=%h, want 1 0 a5", valid_m, perr_m, data_m);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < W; i++) step(1'b0, val[W-1-i], 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      total++;
      if ({valid_m, perr_m, data_m, perr_l} !== {1'b1, 1'b1, 8'hA5, 1'b1}) begin
         bad++;
         $display("FAIL parity_bad: got valid=%b perr=%b data=%h perr_l=%b, want 1 1 a5 1", valid_m, perr_m, data_m, perr_l);
      end
   endtask
`endif

   task automatic test_random();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, 1'($urandom),
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
         total++;
         if ({valid_m, ovf_m, cnt_m, data_m} !== {m_valid, m_ovf, CW'(mq.size()), m_data_m}) begin
            bad++;
            $display("FAIL rand_msb cycle %0d: got v=%b o=%b c=%0d d=%h, want v=%b o=%b c=%0d d=%h",
                     n, valid_m, ovf_m, cnt_m, data_m, m_valid, m_ovf, mq.size(), m_data_m);
         end
         total++;
         if ({valid_l, ovf_l, cnt_l, data_l} !== {m_valid, m_ovf, CW'(mq.size()), m_data_l}) begin
            bad++;
            $display("FAIL rand_lsb cycle %0d: got v=%b o=%b c=%0d d=%h, want v=%b o=%b c=%0d d=%h",
                     n, valid_l, ovf_l, cnt_l, data_l, m_valid, m_ovf, mq.size(), m_data_l);
         end
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
         total++;
         if ({perr_m, perr_l} !== {m_perr, m_perr}) begin
            bad++;
            $display("FAIL rand_parity cycle %0d: got %b/%b, want %b", n, perr_m, perr_l, m_perr);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
